// File: rtl/led_event_blinker.sv
// led_event_blinker: turns one-cycle event pulses into visible LED blinks.
// Each event yields ON_CYCLES lit clocks then OFF_CYCLES dark clocks.
//
// Ports:
//   i_Clk       system clock, all logic on posedge
//   i_Rst_L     asynchronous active-low reset
//   i_Event     one-cycle event pulse, each high cycle is one event
//   o_LED       registered LED drive, 1 = lit
//   o_Busy      high whenever a blink or its trailing gap is in progress
//   o_Pending   events queued behind the current blink
//   o_Overflow  sticky flag, an event was dropped with the queue full
module led_event_blinker #(
    parameter int ON_CYCLES  = 1250000,
    parameter int OFF_CYCLES = 1250000,
    parameter int PEND_W     = 3
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Event,
    output logic              o_LED,
    output logic              o_Busy,
    output logic [PEND_W-1:0] o_Pending,
    output logic              o_Overflow
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    logic last_gap;
    logic start_req;
    logic start;

    // A new blink may only begin from IDLE or on the final gap clock,
    // which keeps blinks back-to-back while still honouring the gap.
    always_comb begin
        last_gap  = (state == GAP) && (timer == '0);
        start_req = i_Event || (o_Pending != '0);
        start     = ((state == IDLE) || last_gap) && start_req;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            timer      <= '0;
            o_LED      <= 1'b0;
            o_Busy     <= 1'b0;
            o_Pending  <= '0;
            o_Overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ON;
                        timer  <= ON_LOAD;
                        o_LED  <= 1'b1;
                        o_Busy <= 1'b1;
                    end
                end
                ON: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        state <= GAP;
                        timer <= OFF_LOAD;
                        o_LED <= 1'b0;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (start) begin
                        state <= ON;
                        timer <= ON_LOAD;
                        o_LED <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    o_LED  <= 1'b0;
                    o_Busy <= 1'b0;
                end
            endcase

            // On a start with a live event and a non-empty queue the
            // increment and the decrement cancel, so nothing changes.
            if (start) begin
                if ((o_Pending != '0) && !i_Event) begin
                    o_Pending <= o_Pending - PEND_W'(1);
                end
            end else if (i_Event) begin
                if (o_Pending == PEND_MAX) begin
                    o_Overflow <= 1'b1;
                end else begin
                    o_Pending <= o_Pending + PEND_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_event_blinker.sv
// tb_led_event_blinker: directed bench for led_event_blinker.
// Uses ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
module tb_led_event_blinker;

    logic       clk;
    logic       rst_n;
    logic       ev;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    led_event_blinker #(
        .ON_CYCLES (4),
        .OFF_CYCLES(3),
        .PEND_W    (2)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Event   (ev),
        .o_LED     (led),
        .o_Busy    (busy),
        .o_Pending (pend),
        .o_Overflow(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ev;
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void r(input logic e, input logic l, input logic b,
                              input logic [1:0] p, input logic o);
        vec_t v;
        v.ev   = e;
        v.led  = l;
        v.busy = b;
        v.pend = p;
        v.ovf  = o;
        vecs.push_back(v);
    endfunction

    function automatic void rn(input int n, input logic e, input logic l,
                               input logic b, input logic [1:0] p,
                               input logic o);
        for (int i = 0; i < n; i++) r(e, l, b, p, o);
    endfunction

    task automatic chk(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got led/busy/pend/ovf=%b_%b_%b_%b want %b_%b_%b_%b",
                     name, act[4], act[3], act[2:1], act[0],
                     exp[4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    function automatic logic [4:0] outs();
        return {led, busy, pend, ovf};
    endfunction

    initial begin
        // single event
        r(1, 1, 1, 0, 0);
        rn(3, 0, 1, 1, 0, 0);
        rn(3, 0, 0, 1, 0, 0);
        rn(2, 0, 0, 0, 0, 0);
        // queued second event, replayed back-to-back
        r(1, 1, 1, 0, 0);
        r(0, 1, 1, 0, 0);
        r(1, 1, 1, 1, 0);
        r(0, 1, 1, 1, 0);
        rn(3, 0, 0, 1, 1, 0);
        rn(4, 0, 1, 1, 0, 0);
        rn(3, 0, 0, 1, 0, 0);
        rn(2, 0, 0, 0, 0, 0);
        // event on the last gap clock with one already pending
        r(1, 1, 1, 0, 0);
        r(0, 1, 1, 0, 0);
        r(1, 1, 1, 1, 0);
        r(0, 1, 1, 1, 0);
        rn(3, 0, 0, 1, 1, 0);
        r(1, 1, 1, 1, 0);
        rn(3, 0, 1, 1, 1, 0);
        rn(3, 0, 0, 1, 1, 0);
        rn(4, 0, 1, 1, 0, 0);
        rn(3, 0, 0, 1, 0, 0);
        r(0, 0, 0, 0, 0);
        // saturation: queue caps at 3, fifth event dropped, 4 blinks
        r(1, 1, 1, 0, 0);
        r(1, 1, 1, 1, 0);
        r(1, 1, 1, 2, 0);
        r(1, 1, 1, 3, 0);
        r(1, 0, 1, 3, 1);
        rn(2, 0, 0, 1, 3, 1);
        rn(4, 0, 1, 1, 2, 1);
        rn(3, 0, 0, 1, 2, 1);
        rn(4, 0, 1, 1, 1, 1);
        rn(3, 0, 0, 1, 1, 1);
        rn(4, 0, 1, 1, 0, 1);
        rn(3, 0, 0, 1, 0, 1);
        rn(2, 0, 0, 0, 0, 1);

        // reset held: outputs stay 0 even with events toggling
        rst_n = 1'b0;
        ev    = 1'b0;
        #1;
        chk("reset_async", outs(), 5'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ev = ~ev;
            @(posedge clk);
            #1;
            chk("reset_held", outs(), 5'b0);
        end
        @(negedge clk);
        ev    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("after_release", outs(), 5'b0);
        end

        // table-driven sequences
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ev = vecs[i].ev;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), outs(),
                {vecs[i].led, vecs[i].busy, vecs[i].pend, vecs[i].ovf});
        end

        // reset mid-blink with events queued and overflow still set
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ev = 1'b1;
            @(posedge clk);
        end
        #1;
        chk("pre_reset_blink", outs(), 5'b11101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_blink_reset", outs(), 5'b0);
        @(negedge clk);
        ev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("no_resume", outs(), 5'b0);
        end

        // fresh blink still works after reset
        @(negedge clk);
        ev = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_blink", outs(), 5'b11000);
        @(negedge clk);
        ev = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
